// File: rtl/packet_disassembler.sv
// packet_disassembler
//   Splits one wide response message into SPI-width packets, most significant packet first.
//   Each instance feeds one request slot of the response arbitrator. send_val stays high
//   across all packets of a message so the grant is held. It then drops for at least one
//   cycle between messages so the arbitrator can re-grant.
//
//   Ports
//     clk       clock
//     reset     synchronous, active-high reset
//     recv_val  upstream message valid
//     recv_rdy  block can accept a message (depends on state only)
//     recv_msg  message to disassemble, nbits wide
//     send_val  packet valid (arbitrator req_val)
//     send_rdy  downstream accepts packet (arbitrator req_rdy)
//     send_msg  current packet, packet_nbits wide (arbitrator req_msg)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no message held; recv_rdy=1, send_val=0, send_msg=0
//   SEND  | presenting top packet of the shift register; recv_val ignored

module packet_disassembler #(
    parameter int nbits        = 32,
    parameter int packet_nbits = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    recv_val,
    output logic                    recv_rdy,
    input  logic [nbits-1:0]        recv_msg,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic [packet_nbits-1:0] send_msg
);

    localparam int num_packets = (nbits + packet_nbits - 1) / packet_nbits;
    localparam int cnt_nbits   = (num_packets > 1) ? $clog2(num_packets) : 1;
    localparam int sr_nbits    = num_packets * packet_nbits;

    localparam logic [cnt_nbits-1:0] last_cnt = cnt_nbits'(num_packets - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [sr_nbits-1:0]    shift_reg, shift_next;
    logic [cnt_nbits-1:0]   count, count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            count     <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        count_next = count;
        recv_rdy   = 1'b0;
        send_val   = 1'b0;
        send_msg   = '0;

        case (state)
            IDLE: begin
                recv_rdy = 1'b1;
                if (recv_val) begin
                    // The cast zero-extends, so any pad bits sit at the top of the first packet.
                    shift_next = sr_nbits'(recv_msg);
                    count_next = '0;
                    state_next = SEND;
                end
            end

            SEND: begin
                send_val = 1'b1;
                send_msg = shift_reg[sr_nbits-1 -: packet_nbits];
                if (send_rdy) begin
                    shift_next = shift_reg << packet_nbits;
                    count_next = count + 1'b1;
                    if (count == last_cnt) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_packet_disassembler.sv
module tb_packet_disassembler;

    logic        clk = 1'b0;
    logic        reset;
    logic        recv_val;
    logic [31:0] recv_msg;
    logic        send_rdy;

    logic        recv_rdy_a, send_val_a;
    logic [7:0]  send_msg_a;
    logic        recv_rdy_b, send_val_b;
    logic [7:0]  send_msg_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the queue of packets still owed for the current message.
    // Empty queue means the block is idle.
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    packet_disassembler #(.nbits(32), .packet_nbits(8)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy_a),
        .recv_msg (recv_msg),
        .send_val (send_val_a),
        .send_rdy (send_rdy),
        .send_msg (send_msg_a)
    );

    packet_disassembler #(.nbits(20), .packet_nbits(8)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy_b),
        .recv_msg (recv_msg[19:0]),
        .send_val (send_val_b),
        .send_rdy (send_rdy),
        .send_msg (send_msg_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Packets of a message of width w, zero-padded to whole bytes, MS byte first.
    task automatic load_model(input int w, input logic [31:0] msg, inout logic [7:0] q[$]);
        int np;
        logic [31:0] m;
        np = (w + 7) / 8;
        m  = (w >= 32) ? msg : (msg & ((32'd1 << w) - 32'd1));
        q.delete();
        for (int i = np - 1; i >= 0; i--) begin
            q.push_back(8'((m >> (i * 8)) & 32'hFF));
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] msg, input logic sr);
        logic exp_rdy_a, exp_rdy_b;
        @(negedge clk);
        reset    = r;
        recv_val = rv;
        recv_msg = msg;
        send_rdy = sr;
        #1;
        exp_rdy_a = (q_a.size() == 0);
        exp_rdy_b = (q_b.size() == 0);
        chk("recv_rdy32", 32'(recv_rdy_a), 32'(exp_rdy_a));
        chk("send_val32", 32'(send_val_a), 32'(!exp_rdy_a));
        chk("send_msg32", 32'(send_msg_a), exp_rdy_a ? 32'h0 : 32'(q_a[0]));
        chk("recv_rdy20", 32'(recv_rdy_b), 32'(exp_rdy_b));
        chk("send_val20", 32'(send_val_b), 32'(!exp_rdy_b));
        chk("send_msg20", 32'(send_msg_b), exp_rdy_b ? 32'h0 : 32'(q_b[0]));
        @(posedge clk);
        if (r) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (exp_rdy_a) begin
                if (rv) load_model(32, msg, q_a);
            end else if (sr) begin
                void'(q_a.pop_front());
            end
            if (exp_rdy_b) begin
                if (rv) load_model(20, msg, q_b);
            end else if (sr) begin
                void'(q_b.pop_front());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        @(posedge clk);

        // Outputs while held in reset, then idle after release.
        step(1, 0, 32'h0, 0);
        step(1, 1, 32'h12345678, 1);
        step(0, 0, 32'h0, 1);

        // Full throughput: DE AD BE EF, then a gap cycle.
        step(0, 1, 32'hDEADBEEF, 1);
        repeat (5) step(0, 0, 32'h0, 1);

        // Stall three cycles on the AD packet.
        step(0, 1, 32'hDEADBEEF, 1);
        step(0, 0, 32'h0, 1);
        repeat (3) step(0, 0, 32'h0, 0);
        repeat (4) step(0, 0, 32'h0, 1);

        // 20-bit instance: 0A BC DE.
        step(0, 1, 32'h000ABCDE, 1);
        repeat (5) step(0, 0, 32'h0, 1);

        // recv_val held: second message taken only in the gap cycle.
        step(0, 1, 32'h11223344, 1);
        repeat (4) step(0, 1, 32'h11223344, 1);
        step(0, 1, 32'h55667788, 1);
        repeat (5) step(0, 0, 32'h0, 1);

        // Reset after two packets accepted.
        step(0, 1, 32'hCAFEF00D, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        repeat (4) step(0, 0, 32'h0, 1);

        // recv_val pulsed with all-ones during SEND is ignored.
        step(0, 1, 32'hDEADBEEF, 1);
        step(0, 1, 32'hFFFFFFFF, 1);
        step(0, 0, 32'h0, 1);
        step(0, 1, 32'hFFFFFFFF, 0);
        repeat (4) step(0, 0, 32'h0, 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 50),
                 $urandom(), ($urandom_range(0, 99) < 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
